flag_ctrl: RTL and testbench

FLAG_CTRL -- requirements
Module: flag_ctrl

---
 rtl/flag_ctrl_if.sv | 41 ++++
 rtl/flag_ctrl.sv | 134 +++++++++++++
 tb/tb_flag_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_ctrl_if.sv
// rtl/flag_ctrl_if.sv - opcode/flag inputs and flag/PC control outputs of flag_ctrl
//
// Signals:
//   OPCODE[6:0], C, Z, I, INTR   : instruction and flag state seen by the controller
//   C_CLEAR, C_SET, C_LD, Z_LD   : carry/zero flag register controls
//   FLG_LD_SEL, FLG_SHAD_LD      : flag source select (0 ALU, 1 shadow) / shadow capture
//   I_SET, I_CLR                 : interrupt-enable controls
//   PC_INC, PC_LD, PC_MUX_SEL    : program counter controls (0 branch, 1 stack, 2 ISR vector)
//   STATE_OUT[1:0]               : current controller state
// Modports: slave = flag_ctrl, master = surrounding datapath / testbench.
interface flag_ctrl_if;
    logic [6:0] OPCODE;
    logic       C;
    logic       Z;
    logic       I;
    logic       INTR;
    logic       C_CLEAR;
    logic       C_SET;
    logic       C_LD;
    logic       Z_LD;
    logic       FLG_LD_SEL;
    logic       FLG_SHAD_LD;
    logic       I_SET;
    logic       I_CLR;
    logic       PC_INC;
    logic       PC_LD;
    logic [1:0] PC_MUX_SEL;
    logic [1:0] STATE_OUT;

    modport slave (
        input  OPCODE, C, Z, I, INTR,
        output C_CLEAR, C_SET, C_LD, Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
               I_SET, I_CLR, PC_INC, PC_LD, PC_MUX_SEL, STATE_OUT
    );

    modport master (
        output OPCODE, C, Z, I, INTR,
        input  C_CLEAR, C_SET, C_LD, Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
               I_SET, I_CLR, PC_INC, PC_LD, PC_MUX_SEL, STATE_OUT
    );
endinterface

// File: rtl/flag_ctrl.sv
// rtl/flag_ctrl.sv - INIT/FETCH/EXEC/INTR control unit driving flag and PC controls
//
// Ports:
//   clk  : rising-edge clock
//   RST  : asynchronous active-high reset, forces INIT (all outputs 0)
//   bus  : flag_ctrl_if.slave - opcode/flag inputs, flag/PC control outputs, STATE_OUT
// Outputs are a combinational decode of the current state and, in EXEC, of OPCODE/C/Z.
module flag_ctrl (
    input  logic         clk,
    input  logic         RST,
    flag_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_BRANCH = 2'd0;
    localparam logic [1:0] SEL_STACK  = 2'd1;
    localparam logic [1:0] SEL_ISR    = 2'd2;

    state_t     state_q;
    state_t     state_d;

    logic       c_clear;
    logic       c_set;
    logic       c_ld;
    logic       z_ld;
    logic       flg_ld_sel;
    logic       flg_shad_ld;
    logic       i_set;
    logic       i_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_mux_sel;
    logic       is_alu;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign is_alu = (bus.OPCODE[6:4] == 3'b000) || (bus.OPCODE[6:5] == 2'b10);

    always_comb begin
        state_d     = state_q;
        c_clear     = 1'b0;
        c_set       = 1'b0;
        c_ld        = 1'b0;
        z_ld        = 1'b0;
        flg_ld_sel  = 1'b0;
        flg_shad_ld = 1'b0;
        i_set       = 1'b0;
        i_clr       = 1'b0;
        pc_inc      = 1'b0;
        pc_ld       = 1'b0;
        pc_mux_sel  = SEL_BRANCH;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                pc_inc  = 1'b1;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                // Interrupt acceptance looks at the registered I flag, not at
                // the I_SET/I_CLR this instruction is issuing.
                state_d = (bus.INTR && bus.I) ? ST_INTR : ST_FETCH;
                if (is_alu) begin
                    c_ld = 1'b1;
                    z_ld = 1'b1;
                end else begin
                    case (bus.OPCODE)
                        7'b0110000: c_clear = 1'b1;
                        7'b0110001: c_set   = 1'b1;
                        7'b0110100: i_set   = 1'b1;
                        7'b0110101: i_clr   = 1'b1;
                        7'b0010100: pc_ld   = bus.C;
                        7'b0010101: pc_ld   = ~bus.C;
                        7'b0010010: pc_ld   = bus.Z;
                        7'b0010011: pc_ld   = ~bus.Z;
                        7'b0110110, 7'b0110111: begin
                            // Return from interrupt: restore flags from shadow
                            pc_ld      = 1'b1;
                            pc_mux_sel = SEL_STACK;
                            flg_ld_sel = 1'b1;
                            c_ld       = 1'b1;
                            z_ld       = 1'b1;
                            i_set      = bus.OPCODE[0];
                            i_clr      = ~bus.OPCODE[0];
                        end
                        default: ;
                    endcase
                end
            end

            ST_INTR: begin
                flg_shad_ld = 1'b1;
                i_clr       = 1'b1;
                pc_ld       = 1'b1;
                pc_mux_sel  = SEL_ISR;
                state_d     = ST_FETCH;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign bus.C_CLEAR     = c_clear;
    assign bus.C_SET       = c_set;
    assign bus.C_LD        = c_ld;
    assign bus.Z_LD        = z_ld;
    assign bus.FLG_LD_SEL  = flg_ld_sel;
    assign bus.FLG_SHAD_LD = flg_shad_ld;
    assign bus.I_SET       = i_set;
    assign bus.I_CLR       = i_clr;
    assign bus.PC_INC      = pc_inc;
    assign bus.PC_LD       = pc_ld;
    assign bus.PC_MUX_SEL  = pc_mux_sel;
    assign bus.STATE_OUT   = state_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb/tb_flag_ctrl.sv - directed self-checking bench for flag_ctrl
module tb_flag_ctrl;

    logic clk;
    logic RST;

    flag_ctrl_if bus ();

    flag_ctrl dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    // {C_CLEAR,C_SET,C_LD,Z_LD,FLG_LD_SEL,FLG_SHAD_LD,I_SET,I_CLR,PC_INC,PC_LD,PC_MUX_SEL}
    wire [11:0] outs = {bus.C_CLEAR, bus.C_SET, bus.C_LD, bus.Z_LD, bus.FLG_LD_SEL,
                        bus.FLG_SHAD_LD, bus.I_SET, bus.I_CLR, bus.PC_INC, bus.PC_LD,
                        bus.PC_MUX_SEL};
    wire [13:0] obs  = {bus.STATE_OUT, outs};

    localparam logic [11:0] O_NONE  = 12'h000;
    localparam logic [11:0] O_FETCH = 12'h008;
    localparam logic [11:0] O_INTR  = 12'h056;
    localparam logic [11:0] O_ALU   = 12'h300;
    localparam logic [11:0] O_CLC   = 12'h800;
    localparam logic [11:0] O_SEC   = 12'h400;
    localparam logic [11:0] O_SEI   = 12'h020;
    localparam logic [11:0] O_CLI   = 12'h010;
    localparam logic [11:0] O_BR    = 12'h004;
    localparam logic [11:0] O_RETID = 12'h395;
    localparam logic [11:0] O_RETIE = 12'h3A5;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [13:0] exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary want summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [6:0] op, input logic c, input logic z,
                          input logic i, input logic intr);
        bus.OPCODE = op;
        bus.C      = c;
        bus.Z      = z;
        bus.I      = i;
        bus.INTR   = intr;
    endtask

    // Leaves the DUT in INIT with RST low, just after a falling edge.
    task automatic do_reset();
        set_in(7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        set_in(7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        #3;
        exp = {2'd0, O_NONE};
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_async: got %h want %h", obs, exp);
        else pass_cnt++;
        @(posedge clk);
        #3;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_held: got %h want %h", obs, exp);
        else pass_cnt++;
        @(negedge clk);
        RST = 1'b0;
        #1;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_release_init: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_sequence();
        logic [1:0] st_exp [4];
        st_exp = '{2'd1, 2'd2, 2'd1, 2'd2};
        do_reset();
        set_in(7'b1111111, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            exp = {st_exp[k], (st_exp[k] == 2'd1) ? O_FETCH : O_NONE};
            total_cnt++;
            if (obs !== exp) $display("FAIL sequence_%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_carry();
        do_reset();
        step();
        set_in(7'b0110001, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        #1;
        exp = {2'd2, O_SEC};
        total_cnt++;
        if (obs !== exp) $display("FAIL carry_sec: got %h want %h", obs, exp);
        else pass_cnt++;
        step();
        bus.OPCODE = 7'b0110000;
        step();
        #1;
        exp = {2'd2, O_CLC};
        total_cnt++;
        if (obs !== exp) $display("FAIL carry_clc: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_decode();
        // {opcode, C, Z, expected outputs}
        logic [20:0] tbl [18];
        tbl = '{
            {7'b0000100, 1'b0, 1'b0, O_ALU},
            {7'b1001010, 1'b1, 1'b0, O_ALU},
            {7'b0110000, 1'b1, 1'b1, O_CLC},
            {7'b0110001, 1'b0, 1'b0, O_SEC},
            {7'b0110100, 1'b0, 1'b0, O_SEI},
            {7'b0110101, 1'b0, 1'b0, O_CLI},
            {7'b0010100, 1'b1, 1'b0, O_BR},
            {7'b0010100, 1'b0, 1'b1, O_NONE},
            {7'b0010101, 1'b0, 1'b0, O_BR},
            {7'b0010101, 1'b1, 1'b0, O_NONE},
            {7'b0010010, 1'b0, 1'b1, O_BR},
            {7'b0010010, 1'b1, 1'b0, O_NONE},
            {7'b0010011, 1'b0, 1'b0, O_BR},
            {7'b0010011, 1'b0, 1'b1, O_NONE},
            {7'b0110110, 1'b0, 1'b0, O_RETID},
            {7'b0110111, 1'b1, 1'b1, O_RETIE},
            {7'b0111000, 1'b1, 1'b1, O_NONE},
            {7'b1100000, 1'b0, 1'b0, O_NONE}
        };
        do_reset();
        step();
        for (int k = 0; k < 18; k++) begin
            set_in(tbl[k][20:14], tbl[k][13], tbl[k][12], 1'b0, 1'b1);
            step();
            #1;
            exp = {2'd2, tbl[k][11:0]};
            total_cnt++;
            if (obs !== exp) $display("FAIL decode_%0d op=%b: got %h want %h", k, tbl[k][20:14], obs, exp);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_alu_intr();
        do_reset();
        step();
        set_in(7'b0000100, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        #1;
        exp = {2'd2, O_ALU};
        total_cnt++;
        if (obs !== exp) $display("FAIL alu_intr_exec: got %h want %h", obs, exp);
        else pass_cnt++;
        step();
        bus.INTR = 1'b0;
        #1;
        exp = {2'd3, O_INTR};
        total_cnt++;
        if (obs !== exp) $display("FAIL alu_intr_state: got %h want %h", obs, exp);
        else pass_cnt++;
        step();
        #1;
        exp = {2'd1, O_FETCH};
        total_cnt++;
        if (obs !== exp) $display("FAIL alu_intr_return_fetch: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_reti();
        do_reset();
        step();
        set_in(7'b0110111, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        #1;
        exp = {2'd2, O_RETIE};
        total_cnt++;
        if (obs !== exp) $display("FAIL retie_exec: got %h want %h", obs, exp);
        else pass_cnt++;
        step();
        #1;
        exp = {2'd1, O_FETCH};
        total_cnt++;
        if (obs !== exp) $display("FAIL retie_next_fetch: got %h want %h", obs, exp);
        else pass_cnt++;
        set_in(7'b0110110, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        #1;
        exp = {2'd3, O_INTR};
        total_cnt++;
        if (obs !== exp) $display("FAIL retid_then_intr: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        set_in(7'b0000100, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        #1;
        RST = 1'b1;
        #1;
        exp = {2'd0, O_NONE};
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_mid_exec: got %h want %h", obs, exp);
        else pass_cnt++;
        #2;
        RST = 1'b0;
        #1;
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_after_pulse: got %h want %h", obs, exp);
        else pass_cnt++;
        step();
        #1;
        exp = {2'd1, O_FETCH};
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_then_fetch: got %h want %h", obs, exp);
        else pass_cnt++;
        set_in(7'b0000100, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        #1;
        RST = 1'b1;
        #1;
        exp = {2'd0, O_NONE};
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_mid_intr: got %h want %h", obs, exp);
        else pass_cnt++;
        #2;
        RST = 1'b0;
        step();
        #1;
        exp = {2'd1, O_FETCH};
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_intr_then_fetch: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    initial begin
        RST = 1'b1;
        set_in(7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_sequence();
        test_carry();
        test_decode();
        test_alu_intr();
        test_reti();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
